// File: rtl/serial_tx_if.sv
// serial_tx_if: CPU write port of the serial console transmitter
interface serial_tx_if;
   logic       cpu_clken;
   logic       we;
   logic [7:0] din;
   logic       busy;
   modport master(output cpu_clken, we, din, input busy);
   modport slave(input cpu_clken, we, din, output busy);
endinterface

// File: rtl/serial_tx.sv
// serial_tx: FIFO-buffered 8N1 serial transmitter timed by cpu_clken pulses
module serial_tx #(
   parameter int BAUD_DIV   = 104,
   parameter int FIFO_DEPTH = 4,
   parameter int STRIP_MSB  = 1
) (
   input  logic        clk25,
   input  logic        rst_n,
   serial_tx_if.slave  cpu,
   output logic        tx_active,
   output logic        tx
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int BW = $clog2(BAUD_DIV);
   localparam logic [7:0] MASK = STRIP_MSB != 0 ? 8'h7f : 8'hff;
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
   state_t        state;
   logic [BW-1:0] baud;
   logic [2:0]    idx;
   logic [7:0]    shift;
   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wp, rp;
   logic [CW-1:0] count;
   logic          full, push, pop, bit_end;
   assign full     = count == CW'(FIFO_DEPTH);
   assign cpu.busy = full;
   assign push     = cpu.cpu_clken & cpu.we & ~full;
   assign bit_end  = baud == '0;
   // IDLE is transparent: the next character can start on the edge STOP ends
   assign pop      = cpu.cpu_clken & (count != '0) & (state == IDLE | (state == STOP & bit_end));
   always_ff @(posedge clk25)
      if (push) mem[wp] <= cpu.din;
   always_ff @(posedge clk25) begin
      if (!rst_n) begin
         state     <= IDLE;
         baud      <= '0;
         idx       <= '0;
         shift     <= '0;
         wp        <= '0;
         rp        <= '0;
         count     <= '0;
         tx        <= 1'b1;
         tx_active <= 1'b0;
      end else begin
         if (push) wp <= wp + AW'(1);
         if (pop) rp <= rp + AW'(1);
         count <= count + CW'(push) - CW'(pop);
         if (pop) begin
            shift     <= mem[rp] & MASK;
            baud      <= BW'(BAUD_DIV - 1);
            tx        <= 1'b0;
            tx_active <= 1'b1;
            state     <= START;
         end else if (cpu.cpu_clken && state != IDLE) begin
            if (!bit_end) baud <= baud - BW'(1);
            else begin
               baud <= BW'(BAUD_DIV - 1);
               case (state)
                  START: begin
                     state <= DATA;
                     idx   <= '0;
                     tx    <= shift[0];
                  end
                  DATA: begin
                     idx   <= idx + 3'd1;
                     shift <= shift >> 1;
                     tx    <= idx == 3'd7 ? 1'b1 : shift[1];
                     state <= idx == 3'd7 ? STOP : DATA;
                  end
                  default: begin
                     state     <= IDLE;
                     tx_active <= 1'b0;
                  end
               endcase
            end
         end
      end
   end
endmodule

// File: tb/tb_serial_tx.sv
// tb_serial_tx: directed vectors for serial_tx with BAUD_DIV=4, cpu_clken every 25 cycles
module tb_serial_tx;
   logic clk25 = 1'b0;
   logic rst_n = 1'b0;
   logic clken = 1'b0;
   logic we = 1'b0;
   logic [7:0] din = 8'h00;
   logic tx_a, act_a, tx_b, act_b;
   int vecs = 0;
   int errs = 0;
   always #20 clk25 = ~clk25;
   serial_tx_if ifa();
   serial_tx_if ifb();
   assign ifa.cpu_clken = clken;
   assign ifa.we = we;
   assign ifa.din = din;
   assign ifb.cpu_clken = clken;
   assign ifb.we = we;
   assign ifb.din = din;
   serial_tx #(.BAUD_DIV(4), .FIFO_DEPTH(4), .STRIP_MSB(1)) dut_a (
      .clk25(clk25), .rst_n(rst_n), .cpu(ifa.slave), .tx_active(act_a), .tx(tx_a));
   serial_tx #(.BAUD_DIV(4), .FIFO_DEPTH(4), .STRIP_MSB(0)) dut_b (
      .clk25(clk25), .rst_n(rst_n), .cpu(ifb.slave), .tx_active(act_b), .tx(tx_b));
   typedef struct {
      logic w;
      int   reps;
      logic tx;
      logic busy;
      logic act;
      logic msb;
   } vec_t;
   vec_t tbl [8];
   int         wpos [6];
   logic [7:0] wdat [6];
   int         bpos [6];
   logic       bval [6];
   int         nfr;
   task automatic chk(input string n, input logic a, input logic e);
      vecs++;
      if (a !== e) begin
         errs++;
         $display("FAIL %s: got %b want %b at %0t", n, a, e, $time);
      end
   endtask
   task automatic do_reset();
      rst_n = 1'b0;
      clken = 1'b0;
      we = 1'b0;
      repeat (3) @(posedge clk25);
      #1;
      chk("reset tx", tx_a, 1'b1);
      chk("reset busy", ifa.busy, 1'b0);
      chk("reset active", act_a, 1'b0);
      rst_n = 1'b1;
      @(posedge clk25);
      #1;
   endtask
   task automatic pulse(input logic w, input logic [7:0] d, input logic r);
      rst_n = r;
      clken = 1'b1;
      we = w;
      din = d;
      @(posedge clk25);
      #1;
      clken = 1'b0;
      we = 1'b0;
      rst_n = 1'b1;
   endtask
   task automatic gap();
      repeat (24) @(posedge clk25);
      #1;
   endtask
   // expected {tx_active, tx} after pulse p for back-to-back frames starting at pulse 2
   function automatic logic [1:0] model(input int p);
      int o, f, b;
      o = p - 2;
      f = o / 40;
      if (p < 2 || f >= nfr) return 2'b01;
      b = (o % 40) / 4;
      if (b == 0) return 2'b10;
      if (b == 9) return 2'b11;
      return {1'b1, wdat[f][b-1]};
   endfunction
   task automatic run_frames(input string tag);
      logic w;
      logic [7:0] d;
      logic [1:0] m;
      for (int p = 1; p <= 2 + 40 * nfr + 8; p++) begin
         w = 1'b0;
         d = 8'h00;
         for (int k = 0; k < 6; k++)
            if (wpos[k] == p) begin
               w = 1'b1;
               d = wdat[k];
            end
         pulse(w, d, 1'b1);
         m = model(p);
         chk({tag, " tx"}, tx_a, m[0]);
         chk({tag, " active"}, act_a, m[1]);
         for (int k = 0; k < 6; k++)
            if (bpos[k] == p) chk({tag, " busy"}, ifa.busy, bval[k]);
         gap();
      end
   endtask
   initial begin
      logic [7:0] ch;
      tbl = '{
         '{1'b1, 1,  1'b1, 1'b0, 1'b0, 1'b0},
         '{1'b0, 4,  1'b0, 1'b0, 1'b1, 1'b0},
         '{1'b0, 4,  1'b1, 1'b0, 1'b1, 1'b0},
         '{1'b0, 20, 1'b0, 1'b0, 1'b1, 1'b0},
         '{1'b0, 4,  1'b1, 1'b0, 1'b1, 1'b0},
         '{1'b0, 4,  1'b0, 1'b0, 1'b1, 1'b1},
         '{1'b0, 4,  1'b1, 1'b0, 1'b1, 1'b0},
         '{1'b0, 3,  1'b1, 1'b0, 1'b0, 1'b0}};
      do_reset();
      for (int c = 0; c < 1000; c++) begin
         clken = (c % 25) == 24;
         @(posedge clk25);
         #1;
         chk("idle tx", tx_a, 1'b1);
         chk("idle busy", ifa.busy, 1'b0);
         chk("idle active", act_a, 1'b0);
      end
      clken = 1'b0;
      we = 1'b1;
      din = 8'h41;
      repeat (100) @(posedge clk25);
      #1;
      we = 1'b0;
      for (int p = 0; p < 10; p++) begin
         pulse(1'b0, 8'h00, 1'b1);
         chk("no clken write tx", tx_a, 1'b1);
         chk("no clken write active", act_a, 1'b0);
         gap();
      end
      for (int pass = 0; pass < 2; pass++) begin
         do_reset();
         ch = pass == 0 ? 8'h41 : 8'hC1;
         for (int i = 0; i < 8; i++)
            for (int r = 0; r < tbl[i].reps; r++) begin
               pulse(tbl[i].w, ch, 1'b1);
               chk("frame tx", tx_a, tbl[i].tx);
               chk("frame busy", ifa.busy, tbl[i].busy);
               chk("frame active", act_a, tbl[i].act);
               chk("nostrip tx", tx_b, tbl[i].tx | (tbl[i].msb & ch[7]));
               chk("nostrip active", act_b, tbl[i].act);
               gap();
               chk("frame tx hold", tx_a, tbl[i].tx);
            end
      end
      do_reset();
      wpos = '{1, 2, 3, 4, 5, 6};
      wdat = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36};
      bpos = '{4, 5, 6, 41, 42, 0};
      bval = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      nfr = 5;
      run_frames("fill");
      do_reset();
      wpos = '{1, 3, 4, 42, 43, 44};
      wdat = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h1F, 8'h6B};
      bpos = '{41, 42, 43, 44, 0, 0};
      bval = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      nfr = 6;
      run_frames("pushpop");
      do_reset();
      for (int p = 1; p <= 18; p++) begin
         pulse(p <= 5, p == 1 ? 8'h55 : 8'(p), 1'b1);
         gap();
      end
      chk("pre-reset busy", ifa.busy, 1'b1);
      chk("pre-reset tx bit3", tx_a, 1'b0);
      chk("pre-reset active", act_a, 1'b1);
      pulse(1'b0, 8'h00, 1'b0);
      chk("midreset tx", tx_a, 1'b1);
      chk("midreset busy", ifa.busy, 1'b0);
      chk("midreset active", act_a, 1'b0);
      gap();
      for (int p = 0; p < 60; p++) begin
         pulse(1'b0, 8'h00, 1'b1);
         chk("post-reset tx", tx_a, 1'b1);
         chk("post-reset active", act_a, 1'b0);
         gap();
      end
      chk("post-reset busy", ifa.busy, 1'b0);
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule

// File: doc/serial_tx.md
Name: serial_tx

Overview:
- Serial console transmitter for the display path.
- The CPU writes characters; they are queued in a small FIFO and shifted out as 8N1 asynchronous serial on `tx`.
- Bit timing is derived by counting `cpu_clken` pulses from the clock-enable generator, so the block runs entirely in the 25 MHz domain with no extra divider from `clk25`.
- `busy` feeds the display-ready status bit read by the CPU.

Parameters:
- BAUD_DIV, 104, number of `cpu_clken` pulses per serial bit (1 MHz / 104 ≈ 9615 baud); legal range 2..1023.
- FIFO_DEPTH, 4, number of character slots; must be a power of two, 2..16.
- STRIP_MSB, 1, when 1 bit 7 of each transmitted character is forced to 0 (the CPU writes characters with bit 7 set).

Ports:
- clk25 input 1: 25 MHz master clock; all logic on its rising edge.
- rst_n input 1: synchronous reset, active low.
- cpu_clken input 1: one-`clk25`-cycle enable, nominally 1 pulse per 25 cycles.
- we input 1: CPU write strobe to the display data register.
- din input 8: character written by the CPU.
- busy output 1: 1 when the FIFO is full; the CPU must not write.
- tx_active output 1: 1 while a frame is on the line (states START, DATA, STOP).
- tx output 1: serial line; idles high.

Behaviour:
- Clocking and reset:
  - Single clock `clk25`; reset is synchronous, active-low on `rst_n`.
  - `rst_n`=0 at an edge forces tx=1, busy=0, tx_active=0, FIFO empty, state IDLE, baud counter 0.
  - Reset mid-frame aborts the frame immediately; `tx` returns high on the same edge and queued data is discarded.
- Write acceptance:
  - A character is accepted only on an edge where we=1, cpu_clken=1 and the FIFO count is below FIFO_DEPTH.
  - "Full" is evaluated on the pre-edge count.
  - A write to a full FIFO is silently dropped and the FIFO is unchanged.
  - `we` without `cpu_clken` is ignored.
- FIFO:
  - Count width is log2(FIFO_DEPTH)+1; read and write pointers wrap modulo FIFO_DEPTH.
  - busy = (count == FIFO_DEPTH), decoded from the registered count.
  - A push and a pop on the same edge leave the count unchanged; both take effect.
  - A pop never occurs when the FIFO is empty.
- Transmit state machine (IDLE, START, DATA, STOP); all transitions occur only on edges with cpu_clken=1:
  - IDLE: if count>0, pop the head into the shift register (bit 7 cleared if STRIP_MSB), load baud counter with BAUD_DIV-1, go to START. `tx` goes low on that edge.
  - Bit timing: in START, DATA and STOP the baud counter decrements on each `cpu_clken`. Reaching 0 ends the current bit; each bit therefore lasts exactly BAUD_DIV `cpu_clken` periods.
  - START ends -> DATA with bit index 0 and tx=shift[0].
  - DATA: after each bit, index increments and the next bit is output, LSB first. After bit 7 -> STOP with tx=1.
  - STOP ends -> IDLE.
  - A queued character may start on the same edge STOP ends (IDLE is transparent for one `cpu_clken`). Minimum frame spacing is exactly 10 bit periods.
- Timing:
  - A write accepted at `cpu_clken` edge N is popped no earlier than `cpu_clken` edge N+1.
  - `tx` is a registered output with no glitches.
- tx_active: 1 from the edge `tx` falls for the start bit until the edge the stop bit ends.
- cpu_clken never asserted: the block holds its state indefinitely, and writes are not accepted.

Test Plan:
1. Reset then idle for 1000 cycles -> tx=1, busy=0, tx_active=0 throughout.
2. BAUD_DIV=4, cpu_clken every 25 cycles; write 0x41 -> tx low 100 clk25 cycles, then bits 1,0,0,0,0,0,1,0 at 100 cycles each, then high 100 cycles; tx_active drops after the stop bit.
3. STRIP_MSB=1; write 0xC1 -> line waveform identical to scenario 2. With STRIP_MSB=0, bit 7 is sent as 1.
4. FIFO fill: writes of 0x31..0x36 on 6 consecutive `cpu_clken` pulses -> 0x31 pops at pulse 2; busy=1 after the 5th write; 0x36 dropped. Line carries 0x31..0x35 back-to-back, exactly 40 `cpu_clken` per frame, then idles. busy drops on the edge of 0x32's pop.
5. Simultaneous push/pop: FIFO count 2 while a frame ends; write on the edge the next character pops -> count stays 2 and ordering is preserved.
6. Reset mid-frame: assert rst_n=0 during DATA bit 3 -> tx=1 and busy=0 on that edge; after release, no residual character is transmitted.
